// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with exception capture and a circular return-address stack.
// Next PC priority: exception, stall, redirect, RAS pop, sequential increment.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int               INC          = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write,
    input  logic                         exc,
    input  logic                         redirect,
    input  logic [WIDTH-1:0]             redirect_target,
    input  logic                         push,
    input  logic                         pop,
    output logic [WIDTH-1:0]             result,
    output logic [WIDTH-1:0]             pc_plus,
    output logic [WIDTH-1:0]             epc,
    output logic [WIDTH-1:0]             ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_underflow,
    output logic                         ras_overflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] entries_q [RAS_DEPTH];
    logic [WIDTH-1:0] entries_d [RAS_DEPTH];
    logic             uf_q, uf_d;
    logic             of_q, of_d;

    logic             empty;
    logic             full;
    logic [PW-1:0]    top_idx;

    // ptr_q is the next free slot; the top entry sits one below it (mod depth).
    assign pc_plus = result_q + WIDTH'(INC);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(RAS_DEPTH));
    assign top_idx = ptr_q - 1'b1;

    always_comb begin
        result_d  = result_q;
        epc_d     = epc_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        entries_d = entries_q;
        uf_d      = 1'b0;
        of_d      = 1'b0;

        if (exc) begin
            result_d = EXC_VECTOR;
            epc_d    = result_q;
        end else if (write) begin
            if (redirect) begin
                result_d = redirect_target;
            end else if (pop && !empty) begin
                result_d = entries_q[top_idx];
            end else begin
                result_d = pc_plus;
            end

            if (push && pop && !empty) begin
                entries_d[top_idx] = pc_plus;
            end else if (push) begin
                // When full the write lands on the oldest slot, overwriting it.
                entries_d[ptr_q] = pc_plus;
                ptr_d            = ptr_q + 1'b1;
                uf_d             = pop;
                if (full) begin
                    of_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (pop) begin
                if (empty) begin
                    uf_d = 1'b1;
                end else begin
                    ptr_d   = top_idx;
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= RESET_VECTOR;
            epc_q    <= '0;
            ptr_q    <= '0;
            count_q  <= '0;
            uf_q     <= 1'b0;
            of_q     <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            result_q  <= result_d;
            epc_q     <= epc_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            uf_q      <= uf_d;
            of_q      <= of_d;
            entries_q <= entries_d;
        end
    end

    assign result        = result_q;
    assign epc           = epc_q;
    assign ras_top       = empty ? '0 : entries_q[top_idx];
    assign ras_count     = count_q;
    assign ras_underflow = uf_q;
    assign ras_overflow  = of_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: hand-derived vector tables applied through an expected-result
// queue, plus an asynchronous reset sequence.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        write, exc, redirect, push, pop;
    logic [31:0] redirect_target;
    logic [31:0] result, pc_plus, epc, ras_top;
    logic [2:0]  ras_count;
    logic        ras_underflow, ras_overflow;

    int n_pass  = 0;
    int n_total = 0;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .write           (write),
        .exc             (exc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .push            (push),
        .pop             (pop),
        .result          (result),
        .pc_plus         (pc_plus),
        .epc             (epc),
        .ras_top         (ras_top),
        .ras_count       (ras_count),
        .ras_underflow   (ras_underflow),
        .ras_overflow    (ras_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w, e, r;
        logic [31:0] tgt;
        logic        pu, po;
        logic [31:0] res;
        logic [2:0]  cnt;
        logic [31:0] top;
        logic        uf, of;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic w, logic e, logic r, logic [31:0] tgt, logic pu, logic po,
                                logic [31:0] res, logic [2:0] cnt, logic [31:0] top,
                                logic uf, logic of, logic [31:0] ep);
        vec_t v;
        v.w = w; v.e = e; v.r = r; v.tgt = tgt; v.pu = pu; v.po = po;
        v.res = res; v.cnt = cnt; v.top = top; v.uf = uf; v.of = of; v.epc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_state(input string tag, input vec_t e);
        chk({tag, " result"},   result, e.res);
        chk({tag, " pc_plus"},  pc_plus, e.res + 32'd4);
        chk({tag, " count"},    {29'd0, ras_count}, {29'd0, e.cnt});
        chk({tag, " ras_top"},  ras_top, e.top);
        chk({tag, " underflow"}, {31'd0, ras_underflow}, {31'd0, e.uf});
        chk({tag, " overflow"}, {31'd0, ras_overflow}, {31'd0, e.of});
        chk({tag, " epc"},      epc, e.epc);
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        write = v.w; exc = v.e; redirect = v.r; redirect_target = v.tgt;
        push = v.pu; pop = v.po;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_state($sformatf("vec%0d", idx), e);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t rst_exp;
        reset = 1'b1; write = 0; exc = 0; redirect = 0; push = 0; pop = 0;
        redirect_target = '0;

        //          w e r tgt           pu po  result        cnt top           uf of epc
        tbl_a.push_back(mk(1,0,0,32'h0,  0,0, 32'h4,        0, 32'h0,        0,0, 32'h0));
        tbl_a.push_back(mk(1,0,0,32'h0,  0,0, 32'h8,        0, 32'h0,        0,0, 32'h0));
        tbl_a.push_back(mk(1,0,0,32'h0,  0,0, 32'hC,        0, 32'h0,        0,0, 32'h0));
        tbl_a.push_back(mk(1,0,1,32'h10, 1,0, 32'h10,       1, 32'h10,       0,0, 32'h0));

        tbl_b.push_back(mk(1,0,1,32'h10, 0,0, 32'h10,       0, 32'h0,        0,0, 32'h0));
        tbl_b.push_back(mk(0,0,0,32'h0,  0,0, 32'h10,       0, 32'h0,        0,0, 32'h0));
        tbl_b.push_back(mk(0,0,1,32'h999,1,1, 32'h10,       0, 32'h0,        0,0, 32'h0));
        tbl_b.push_back(mk(0,1,0,32'h0,  0,0, 32'h80000180, 0, 32'h0,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,1,32'h100,0,0, 32'h100,      0, 32'h0,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,1,32'h400,1,0, 32'h400,      1, 32'h104,      0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  0,1, 32'h104,      0, 32'h0,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,1,32'h0,  0,0, 32'h0,        0, 32'h0,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,1,32'h10, 1,0, 32'h10,       1, 32'h4,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,1,32'h20, 1,0, 32'h20,       2, 32'h14,       0,0, 32'h10));
        tbl_b.push_back(mk(1,0,1,32'h30, 1,0, 32'h30,       3, 32'h24,       0,0, 32'h10));
        tbl_b.push_back(mk(1,0,1,32'h40, 1,0, 32'h40,       4, 32'h34,       0,0, 32'h10));
        tbl_b.push_back(mk(1,0,1,32'h50, 1,0, 32'h50,       4, 32'h44,       0,1, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  0,1, 32'h44,       3, 32'h34,       0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  0,1, 32'h34,       2, 32'h24,       0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  0,1, 32'h24,       1, 32'h14,       0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  0,1, 32'h14,       0, 32'h0,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,1,32'h20, 0,0, 32'h20,       0, 32'h0,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  0,1, 32'h24,       0, 32'h0,        1,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  0,0, 32'h28,       0, 32'h0,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  1,0, 32'h2C,       1, 32'h2C,       0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  1,1, 32'h2C,       1, 32'h30,       0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  0,1, 32'h30,       0, 32'h0,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  1,1, 32'h34,       1, 32'h34,       1,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  0,1, 32'h34,       0, 32'h0,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,1,32'hFFFFFFFC,0,0, 32'hFFFFFFFC, 0, 32'h0,   0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  0,0, 32'h0,        0, 32'h0,        0,0, 32'h10));
        tbl_b.push_back(mk(1,0,0,32'h0,  1,0, 32'h4,        1, 32'h4,        0,0, 32'h10));
        tbl_b.push_back(mk(1,1,1,32'h777,0,1, 32'h80000180, 1, 32'h4,        0,0, 32'h4));
        tbl_b.push_back(mk(0,0,0,32'h0,  0,0, 32'h80000180, 1, 32'h4,        0,0, 32'h4));

        rst_exp = mk(0,0,0,32'h0, 0,0, 32'h0, 0, 32'h0, 0,0, 32'h0);

        #12;
        check_state("reset", rst_exp);
        #5;
        reset = 1'b0;

        for (int i = 0; i < tbl_a.size(); i++) step(tbl_a[i], i);

        // Asynchronous reset in mid-cycle, held across an edge with controls active.
        write = 1; push = 1; redirect = 0;
        #2;
        reset = 1'b1;
        #1;
        check_state("async_reset", rst_exp);
        @(posedge clk);
        #1;
        check_state("reset_held", rst_exp);
        push = 0; write = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl_b.size(); i++) step(tbl_b[i], 100 + i);

        chk("scoreboard drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter block for the MIPS fetch stage. It holds the current fetch address and selects the next one from these sources: reset vector, exception vector, redirect target, return-address-stack (RAS) top, or sequential increment. It contains a circular RAS of configurable depth that is pushed on calls and popped on returns. It also captures the faulting PC into an EPC register on exceptions.

Parameters:
WIDTH, 32, address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h8000_0180, PC value loaded on exception
INC, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address-stack entries (power of 2, at least 2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
write  in  1  update enable; 0 = stall, all state held except on exception
exc  in  1  exception request; takes effect even when write=0
redirect  in  1  load redirect_target (branch/jump)
redirect_target  in  WIDTH  redirect address
push  in  1  call: push result+INC onto RAS
pop  in  1  return: next PC from RAS top
result  out  WIDTH  current PC (registered)
pc_plus  out  WIDTH  result+INC (combinational)
epc  out  WIDTH  PC captured at last exception
ras_top  out  WIDTH  current RAS top entry (0 when empty)
ras_count  out  clog2(RAS_DEPTH)+1  valid entries
ras_underflow  out  1  one-cycle pulse: pop when empty
ras_overflow  out  1  one-cycle pulse: push when full

Behaviour:
- Reset (async, any time, including mid-stall or mid-exception): result=RESET_VECTOR, epc=0, ras_count=0, RAS pointer=0, entries=0, both pulses=0. The first edge after reset deasserts applies the normal rules.
- All state updates on the rising clk edge. There is one cycle of latency from inputs to result.
- Next-PC priority per edge:
  1. exc=1: result<=EXC_VECTOR, epc<=result. write is ignored. push and pop are ignored, so the RAS is unchanged.
  2. write=0: hold everything. Pulses go to 0.
  3. redirect=1: result<=redirect_target.
  4. pop=1: result<=RAS top, or result+INC if the RAS is empty.
  5. Otherwise: result<=result+INC.
- Arithmetic is modulo 2^WIDTH. result+INC wraps from all-ones to low addresses with no flag.
- RAS operations happen only when write=1 and exc=0:
  - push only: store result+INC at the top. If count<RAS_DEPTH, count increments. If count==RAS_DEPTH, the oldest entry is overwritten (circular), count stays at RAS_DEPTH, and ras_overflow pulses.
  - pop only: if count>0, count decrements and the pointer retreats. If count==0, the RAS is unchanged and ras_underflow pulses.
  - push and pop together: the top entry is replaced with result+INC and count is unchanged. The next PC is the old top, subject to redirect priority. If count==0, this behaves as a push plus ras_underflow, and the next PC is result+INC.
  - redirect with push (jal): the target is taken and the push still happens.
  - redirect with pop: the target is taken and the pop still happens.
- Pulse outputs are registered. Each is high for exactly the cycle after the triggering edge and low otherwise.
- epc changes only on exception.

Test Plan:
- Reset, then 3 edges with write=1 and no controls -> result goes 0, 4, 8, 12. Assert reset asynchronously mid-cycle -> result=0 immediately, ras_count=0.
- write=0 for 2 edges at result=0x10 -> result stays 0x10. Then exc=1 with write=0 -> result=0x80000180, epc=0x10.
- At result=0x100: push with redirect_target=0x400 -> result=0x400, ras_top=0x104, ras_count=1. Then a pop -> result=0x104, ras_count=0.
- With RAS_DEPTH=4, do 5 pushes from PCs 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_overflow pulses on the 5th push, count=4. Then 4 pops return 0x44, 0x34, 0x24, 0x14.
- Pop on an empty RAS at result=0x20 -> result=0x24, ras_underflow high for one cycle, count stays 0.
- At result=0xFFFFFFFC with a sequential step -> result=0x0. Same-edge exc, redirect and pop -> result=EXC_VECTOR and the RAS is unchanged.
